// File: rtl/imem_pkg.sv
// Shared types and default sizing for the dual-port instruction memory loader.
package imem_pkg;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StLoad
  } state_e;

  localparam int unsigned DefInstrWidth = 20;
  localparam int unsigned DefMemSize    = 32;

endpackage

// File: rtl/imem_array.sv
// 1W1R synchronous storage, read-first on same-address collisions; contents are not reset.
module imem_array #(
  parameter int unsigned Width = 20,
  parameter int unsigned Depth = 32,
  parameter int unsigned AddrW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset, so fetch_data starts at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_loader_dp.sv
// Instruction memory with streaming load port, fetch port and sequenced clear sweep.
// Optional stored even parity per word when IMEM_PARITY_EN is defined.
module imem_loader_dp
  import imem_pkg::*;
#(
  parameter int unsigned INSTRUCTION_WIDTH = DefInstrWidth,
  parameter int unsigned MEMORY_SIZE       = DefMemSize,
  parameter int unsigned ADDR_W            = $clog2(MEMORY_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_req,
  input  logic                         load_start,
  input  logic [ADDR_W-1:0]            load_base,
  input  logic                         load_valid,
  input  logic                         load_last,
  input  logic [INSTRUCTION_WIDTH-1:0] load_data,
  output logic                         load_ready,
  output logic                         load_done,
  output logic [ADDR_W:0]              load_count,
  input  logic                         fetch_req,
  input  logic [ADDR_W-1:0]            fetch_addr,
  output logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [INSTRUCTION_WIDTH-1:0] fetch_data,
  output logic                         fetch_err
);

`ifdef IMEM_PARITY_EN
  localparam int unsigned StoreW = INSTRUCTION_WIDTH + 1;
`else
  localparam int unsigned StoreW = INSTRUCTION_WIDTH;
`endif

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MEMORY_SIZE - 1);
  localparam logic [ADDR_W:0]   SizeCnt  = (ADDR_W + 1)'(MEMORY_SIZE);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   done_q, done_d;
  logic                   fvalid_q;
  logic                   oor_q;

  logic                   we;
  logic [ADDR_W-1:0]      waddr;
  logic [INSTRUCTION_WIDTH-1:0] wdata_raw;
  logic [StoreW-1:0]      wdata;
  logic [StoreW-1:0]      rdata;
  logic                   accept;
  logic                   fetch_oor;
  logic                   par_err;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    done_d    = 1'b0;
    we        = 1'b0;
    waddr     = wr_ptr_q;
    wdata_raw = '0;
    unique case (state_q)
      StClear: begin
        we    = 1'b1;
        waddr = clr_ptr_q;
        if (clr_ptr_q == LastAddr) begin
          state_d   = StIdle;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        end
      end
      StIdle: begin
        if (clear_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end else if (load_start) begin
          state_d  = StLoad;
          // Out-of-range base still opens a session, starting at word 0.
          wr_ptr_d = ({1'b0, load_base} >= SizeCnt) ? '0 : load_base;
          count_d  = '0;
        end
      end
      StLoad: begin
        if (load_valid) begin
          we        = 1'b1;
          wdata_raw = load_data;
          wr_ptr_d  = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + ADDR_W'(1);
          if (count_q != SizeCnt) begin
            count_d = count_q + (ADDR_W + 1)'(1);
          end
          if (load_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  assign fetch_ready = (state_q != StClear);
  assign accept      = fetch_req && fetch_ready;
  assign fetch_oor   = ({1'b0, fetch_addr} >= SizeCnt);

  // oor_q only moves on an accepted fetch so held data/err stay consistent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fvalid_q <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      fvalid_q <= accept;
      if (accept) begin
        oor_q <= fetch_oor;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  assign wdata   = {^wdata_raw, wdata_raw};
  assign par_err = ^rdata;
`else
  assign wdata   = wdata_raw;
  assign par_err = 1'b0;
`endif

  imem_array #(
    .Width (StoreW),
    .Depth (MEMORY_SIZE),
    .AddrW (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (accept && !fetch_oor),
    .raddr (fetch_addr),
    .rdata (rdata)
  );

  assign load_ready  = (state_q == StLoad);
  assign load_done   = done_q;
  assign load_count  = count_q;
  assign fetch_valid = fvalid_q;
  assign fetch_data  = oor_q ? '0 : rdata[INSTRUCTION_WIDTH-1:0];
  assign fetch_err   = oor_q | par_err;

endmodule

// File: tb/tb_imem_loader_dp.sv
// Directed bench for imem_loader_dp: a 32-word instance and a 20-word instance.
module tb_imem_loader_dp;

  logic        clk = 1'b0;
  logic        reset;

  logic        clear_req, load_start, load_valid, load_last, fetch_req;
  logic [4:0]  load_base, fetch_addr;
  logic [19:0] load_data;
  logic        load_ready, load_done, fetch_ready, fetch_valid, fetch_err;
  logic [5:0]  load_count;
  logic [19:0] fetch_data;

  logic        d2_clear_req, d2_load_start, d2_load_valid, d2_load_last, d2_fetch_req;
  logic [4:0]  d2_load_base, d2_fetch_addr;
  logic [19:0] d2_load_data;
  logic        d2_load_ready, d2_load_done, d2_fetch_ready, d2_fetch_valid, d2_fetch_err;
  logic [5:0]  d2_load_count;
  logic [19:0] d2_fetch_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int z1, z2;

  always #5 clk = ~clk;

  imem_loader_dp #(
    .INSTRUCTION_WIDTH (20),
    .MEMORY_SIZE       (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_req   (clear_req),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_last   (load_last),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .load_count  (load_count),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err)
  );

  imem_loader_dp #(
    .INSTRUCTION_WIDTH (20),
    .MEMORY_SIZE       (20)
  ) dut2 (
    .clk         (clk),
    .reset       (reset),
    .clear_req   (d2_clear_req),
    .load_start  (d2_load_start),
    .load_base   (d2_load_base),
    .load_valid  (d2_load_valid),
    .load_last   (d2_load_last),
    .load_data   (d2_load_data),
    .load_ready  (d2_load_ready),
    .load_done   (d2_load_done),
    .load_count  (d2_load_count),
    .fetch_req   (d2_fetch_req),
    .fetch_addr  (d2_fetch_addr),
    .fetch_ready (d2_fetch_ready),
    .fetch_valid (d2_fetch_valid),
    .fetch_data  (d2_fetch_data),
    .fetch_err   (d2_fetch_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Counts cycles with fetch_ready low on each instance, bounded to 40 cycles.
  task automatic measure_clear(input string tag, input int exp1, input int exp2);
    z1 = 0;
    z2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!fetch_ready) z1++;
      if (!d2_fetch_ready) z2++;
      step();
    end
    chk({tag, "_clr32"}, z1, exp1);
    chk({tag, "_clr20"}, z2, exp2);
  endtask

  task automatic fetch1(input string tag, input logic [4:0] a, input logic [19:0] d,
                        input logic e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req = 1'b0;
    chk({tag, "_valid"}, fetch_valid, 1);
    chk({tag, "_data"}, fetch_data, d);
    chk({tag, "_err"}, fetch_err, e);
  endtask

  task automatic fetch2(input string tag, input logic [4:0] a, input logic [19:0] d,
                        input logic e);
    d2_fetch_req  = 1'b1;
    d2_fetch_addr = a;
    step();
    d2_fetch_req = 1'b0;
    chk({tag, "_valid"}, d2_fetch_valid, 1);
    chk({tag, "_data"}, d2_fetch_data, d);
    chk({tag, "_err"}, d2_fetch_err, e);
  endtask

  task automatic start1(input logic [4:0] base);
    load_start = 1'b1;
    load_base  = base;
    step();
    load_start = 1'b0;
  endtask

  task automatic beat1(input logic v, input logic l, input logic [19:0] d);
    load_valid = v;
    load_last  = l;
    load_data  = d;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    {clear_req, load_start, load_valid, load_last, fetch_req} = '0;
    load_base = '0; fetch_addr = '0; load_data = '0;
    {d2_clear_req, d2_load_start, d2_load_valid, d2_load_last, d2_fetch_req} = '0;
    d2_load_base = '0; d2_fetch_addr = '0; d2_load_data = '0;

    // Reset state
    repeat (3) step();
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_fetch_err", fetch_err, 0);

    reset = 1'b1;
    measure_clear("init", 32, 20);
    fetch1("f5_after_clear", 5'd5, 20'h0, 1'b0);

    // Session at base 3
    start1(5'd3);
    chk("s1_load_ready", load_ready, 1);
    beat1(1, 0, 20'hA0001);
    beat1(1, 0, 20'hA0002);
    beat1(1, 0, 20'hA0003);
    beat1(1, 1, 20'hA0004);
    chk("s1_done", load_done, 1);
    chk("s1_count", load_count, 4);
    chk("s1_ready_off", load_ready, 0);
    step();
    chk("s1_done_pulse", load_done, 0);
    fetch1("s1_f3", 5'd3, 20'hA0001, 1'b0);
    fetch1("s1_f4", 5'd4, 20'hA0002, 1'b0);
    fetch1("s1_f5", 5'd5, 20'hA0003, 1'b0);
    fetch1("s1_f6", 5'd6, 20'hA0004, 1'b0);
    step();
    chk("hold_valid", fetch_valid, 0);
    chk("hold_data", fetch_data, 20'hA0004);

    // Wrap from base 30
    start1(5'd30);
    beat1(1, 0, 20'hB0001);
    beat1(1, 0, 20'hB0002);
    beat1(1, 0, 20'hB0003);
    beat1(1, 1, 20'hB0004);
    chk("s2_count", load_count, 4);
    fetch1("s2_f0", 5'd0, 20'hB0003, 1'b0);
    fetch1("s2_f1", 5'd1, 20'hB0004, 1'b0);
    fetch1("s2_f31", 5'd31, 20'hB0002, 1'b0);
    fetch1("s2_f30", 5'd30, 20'hB0001, 1'b0);

    // Gaps: load_last without load_valid must not end the session
    start1(5'd10);
    beat1(1, 0, 20'hC0001);
    beat1(0, 1, 20'hEEEEE);
    chk("s3_gap_ready", load_ready, 1);
    chk("s3_gap_done", load_done, 0);
    beat1(1, 0, 20'hC0002);
    beat1(0, 0, 20'hDDDDD);
    beat1(1, 1, 20'hC0003);
    chk("s3_done", load_done, 1);
    chk("s3_count", load_count, 3);
    fetch1("s3_f10", 5'd10, 20'hC0001, 1'b0);
    fetch1("s3_f11", 5'd11, 20'hC0002, 1'b0);
    fetch1("s3_f12", 5'd12, 20'hC0003, 1'b0);
    fetch1("s3_f13", 5'd13, 20'h0, 1'b0);

    // Same-cycle write and fetch at address 7: read-first
    start1(5'd7);
    beat1(1, 1, 20'hE0000);
    start1(5'd7);
    load_valid = 1'b1; load_last = 1'b1; load_data = 20'hD0001;
    fetch_req  = 1'b1; fetch_addr = 5'd7;
    step();
    load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
    chk("rf_data_old", fetch_data, 20'hE0000);
    chk("rf_done", load_done, 1);
    fetch1("rf_new", 5'd7, 20'hD0001, 1'b0);

    // 20-word instance: out-of-range base, in/out-of-range fetches
    d2_load_start = 1'b1; d2_load_base = 5'd25;
    step();
    d2_load_start = 1'b0;
    chk("d2_load_ready", d2_load_ready, 1);
    d2_load_valid = 1'b1; d2_load_last = 1'b1; d2_load_data = 20'hF0001;
    step();
    d2_load_valid = 1'b0; d2_load_last = 1'b0;
    chk("d2_done", d2_load_done, 1);
    chk("d2_count", d2_load_count, 1);
    fetch2("d2_f0", 5'd0, 20'hF0001, 1'b0);
    fetch2("d2_f25", 5'd25, 20'h0, 1'b1);
    fetch2("d2_f19", 5'd19, 20'h0, 1'b0);
    fetch2("d2_f20", 5'd20, 20'h0, 1'b1);

    // clear_req beats load_start in IDLE
    clear_req = 1'b1; load_start = 1'b1; load_base = 5'd0;
    step();
    clear_req = 1'b0; load_start = 1'b0;
    chk("prio_load_ready", load_ready, 0);
    chk("prio_fetch_ready", fetch_ready, 0);
    fetch_req = 1'b1; fetch_addr = 5'd3;
    step();
    fetch_req = 1'b0;
    chk("clr_fetch_blocked", fetch_valid, 0);
    z1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (!fetch_ready) z1++;
      step();
    end
    chk("prio_clr_len", z1, 31);
    fetch1("prio_f3", 5'd3, 20'h0, 1'b0);

    // Reset in the middle of a session
    start1(5'd0);
    beat1(1, 0, 20'h90001);
    chk("mid_count", load_count, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", load_ready, 0);
    chk("mid_rst_count", load_count, 0);
    step();
    reset = 1'b1;
    chk("mid_rst_done", load_done, 0);
    measure_clear("mid", 32, 20);
    chk("mid_no_done", load_done, 0);
    fetch1("mid_f0", 5'd0, 20'h0, 1'b0);
    fetch2("mid_d2_f0", 5'd0, 20'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
